// File: rtl/key_recover_256to32.sv
// key_recover_256to32: inverse/checker for the 32-to-256 key expander.
// Recovers key K = chunk0 and stage S = chunk0 ^ chunk1 from a 256-bit
// expanded key. It then regenerates chunks 2..7 and compares them with the
// stored input, CHUNKS_PER_CYCLE chunks per CHECK cycle, and builds an
// 8-bit mismatch mask.
// Optional macro KEY_RECOVER_EARLY_ABORT_EN: finish after the first CHECK
// group that contains a mismatch, instead of checking every group.
module key_recover_256to32 #(
  parameter int CHUNKS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] expanded_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  key,
  output logic [31:0]  stage,
  output logic         match,
  output logic [7:0]   err_mask
);

  localparam int GROUPS = 6 / CHUNKS_PER_CYCLE;

  generate
    if (!(CHUNKS_PER_CYCLE == 1 || CHUNKS_PER_CYCLE == 2 ||
          CHUNKS_PER_CYCLE == 3 || CHUNKS_PER_CYCLE == 6)) begin : g_bad_cpc
      $fatal(1, "key_recover_256to32: CHUNKS_PER_CYCLE must be 1, 2, 3 or 6");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [191:0]  chunks_r;     // chunks 2..7 of the accepted key
  logic [31:0]   key_r;
  logic [31:0]   stage_r;
  logic [7:0]    mask_r;
  logic [2:0]    group_r;
  logic          match_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          in_ready_s;
  logic          out_valid_s;
  logic [7:0]    group_mask_s;
  logic [2:0]    chunk_idx_s;
  logic          last_group_s;
  logic          accept_s;

  // Chunk that the expander would have produced at position idx (2..7).
  function automatic logic [31:0] expected_chunk(input logic [2:0] idx,
                                                 input logic [31:0] k,
                                                 input logic [31:0] s);
    case (idx)
      3'd2:    expected_chunk = k ^ {s[15:0], s[31:16]};
      3'd3:    expected_chunk = k ^ ~s;
      3'd4:    expected_chunk = k ^ {s[23:0], s[31:24]};
      3'd5:    expected_chunk = k ^ {s[30:0], 1'b0};
      3'd6:    expected_chunk = k ^ {3'b000, s[31:3]};
      3'd7:    expected_chunk = k ^ s ^ 32'hA5A5_A5A5;
      default: expected_chunk = k;
    endcase
  endfunction

  // Stored chunk at position idx (2..7); chunk 2 sits in the MSBs.
  function automatic logic [31:0] stored_chunk(input logic [191:0] c,
                                               input logic [2:0] idx);
    case (idx)
      3'd2:    stored_chunk = c[191:160];
      3'd3:    stored_chunk = c[159:128];
      3'd4:    stored_chunk = c[127:96];
      3'd5:    stored_chunk = c[95:64];
      3'd6:    stored_chunk = c[63:32];
      3'd7:    stored_chunk = c[31:0];
      default: stored_chunk = 32'd0;
    endcase
  endfunction

  assign accept_s = (state_r == ST_IDLE) && in_valid;

  // Mismatch bits for the chunks belonging to the current CHECK group.
  always_comb begin
    group_mask_s = 8'd0;
    chunk_idx_s  = 3'd2;
    for (int j = 0; j < CHUNKS_PER_CYCLE; j++) begin
      chunk_idx_s = 3'(2 + int'(group_r) * CHUNKS_PER_CYCLE + j);
      if ((chunk_idx_s >= 3'd2) &&
          (stored_chunk(chunks_r, chunk_idx_s) !=
           expected_chunk(chunk_idx_s, key_r, stage_r))) begin
        group_mask_s[chunk_idx_s] = 1'b1;
      end else begin
        group_mask_s[chunk_idx_s] = 1'b0;
      end
    end
  end

  // Decide whether the group being checked this cycle is the final one.
  always_comb begin
`ifdef KEY_RECOVER_EARLY_ABORT_EN
    last_group_s = (group_r == 3'(GROUPS - 1)) || (group_mask_s != 8'd0);
`else
    last_group_s = (group_r == 3'(GROUPS - 1));
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: accept -> walk the groups -> hold until out_ready.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_s = ST_CHECK;
        else          state_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (last_group_s) state_s = ST_DONE;
        else              state_s = ST_CHECK;
      end
      ST_DONE: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs for the upcoming state, registered below.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_s)
      ST_IDLE:  in_ready_s  = 1'b1;
      ST_CHECK: in_ready_s  = 1'b0;
      ST_DONE:  out_valid_s = 1'b1;
      default:  in_ready_s  = 1'b1;
    endcase
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Capture the key at accept, then accumulate the mask group by group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunks_r <= 192'd0;
      key_r    <= 32'd0;
      stage_r  <= 32'd0;
      mask_r   <= 8'd0;
      group_r  <= 3'd0;
      match_r  <= 1'b0;
    end else if (accept_s) begin
      chunks_r <= expanded_key[191:0];
      key_r    <= expanded_key[255:224];
      stage_r  <= expanded_key[255:224] ^ expanded_key[223:192];
      mask_r   <= 8'd0;
      group_r  <= 3'd0;
      match_r  <= 1'b0;
    end else if (state_r == ST_CHECK) begin
      mask_r  <= mask_r | group_mask_s;
      group_r <= group_r + 3'd1;
      if (last_group_s) begin
        match_r <= ((mask_r | group_mask_s) == 8'd0);
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign key       = key_r;
  assign stage     = stage_r;
  assign match     = match_r;
  assign err_mask  = mask_r;

endmodule

// File: tb/tb_key_recover_256to32.sv
// Testbench for key_recover_256to32. Two instances (CHUNKS_PER_CYCLE = 1
// and 3) share the same stimulus. A transaction-level model predicts the
// handshake and the result of each instance from the recovery rules. Literal
// expectations for the documented vectors pin that model.
module tb_key_recover_256to32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [255:0] expanded_key;
  logic         in_ready_o  [2];
  logic         out_valid_o [2];
  logic [31:0]  key_o       [2];
  logic [31:0]  stage_o     [2];
  logic         match_o     [2];
  logic [7:0]   err_mask_o  [2];

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] GOLD = {32'h12345678, 32'h12345679, 32'h12355678, 32'hEDCBA986,
                                   32'h12345778, 32'h1234567A, 32'h12345678, 32'hB791F3DC};
  localparam logic [255:0] CORR5 = {32'h12345678, 32'h12345679, 32'h12355678, 32'hEDCBA986,
                                    32'h12345778, 32'h1234567B, 32'h12345678, 32'hB791F3DC};
  localparam logic [255:0] MULTI = {32'h12345678, 32'h12345679, 32'h12355679, 32'hEDCBA986,
                                    32'h12345778, 32'h1234567A, 32'h12345678, 32'h3791F3DC};
  localparam logic [255:0] EDGEV = {32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                                    32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1FFFFFFF, 32'h5A5A5A5A};

  always #5 clk = ~clk;

  key_recover_256to32 #(.CHUNKS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .expanded_key(expanded_key), .out_valid(out_valid_o[0]), .out_ready(out_ready),
    .key(key_o[0]), .stage(stage_o[0]), .match(match_o[0]), .err_mask(err_mask_o[0]));

  key_recover_256to32 #(.CHUNKS_PER_CYCLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .expanded_key(expanded_key), .out_valid(out_valid_o[1]), .out_ready(out_ready),
    .key(key_o[1]), .stage(stage_o[1]), .match(match_o[1]), .err_mask(err_mask_o[1]));

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_chunk(input int i, input logic [31:0] k, input logic [31:0] s);
    case (i)
      2:       return k ^ ((s << 16) | (s >> 16));
      3:       return k ^ ~s;
      4:       return k ^ ((s << 8) | (s >> 24));
      5:       return k ^ (s << 1);
      6:       return k ^ (s >> 3);
      7:       return k ^ s ^ 32'hA5A5A5A5;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int first_bad(input logic [255:0] v);
    logic [31:0] k;
    logic [31:0] s;
    k = v[255:224];
    s = k ^ v[223:192];
    for (int i = 2; i < 8; i++) begin
      if (v[255-32*i -: 32] != exp_chunk(i, k, s)) return i;
    end
    return 8;
  endfunction

  function automatic logic [7:0] model_mask(input logic [255:0] v, input int cpc);
    logic [31:0] k;
    logic [31:0] s;
    logic [7:0]  m;
    int          limit;
    k = v[255:224];
    s = k ^ v[223:192];
    m = 8'h00;
    limit = 8;
`ifdef KEY_RECOVER_EARLY_ABORT_EN
    if (first_bad(v) < 8) limit = 2 + ((first_bad(v) - 2) / cpc + 1) * cpc;
`endif
    for (int i = 2; i < limit; i++) begin
      if (v[255-32*i -: 32] != exp_chunk(i, k, s)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int model_groups(input logic [255:0] v, input int cpc);
`ifdef KEY_RECOVER_EARLY_ABORT_EN
    if (first_bad(v) < 8) return (first_bad(v) - 2) / cpc + 1;
`endif
    return 6 / cpc;
  endfunction

  function automatic int cpc_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  bit          m_busy  [2];
  bit          m_valid [2];
  int          m_cnt   [2];
  logic [31:0] m_key   [2];
  logic [31:0] m_stage [2];
  logic [7:0]  m_mask  [2];
  int          acc_cnt [2];
  int          acc_cyc [2];
  int          cyc;

  // Transaction model: accept when idle, produce the result after the group count, hold until out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int d = 0; d < 2; d++) begin
        m_busy[d]  <= 1'b0;
        m_valid[d] <= 1'b0;
        m_cnt[d]   <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
        if (!m_busy[d] && !m_valid[d]) begin
          if (in_valid) begin
            m_busy[d]  <= 1'b1;
            m_cnt[d]   <= model_groups(expanded_key, cpc_of(d));
            m_key[d]   <= expanded_key[255:224];
            m_stage[d] <= expanded_key[255:224] ^ expanded_key[223:192];
            m_mask[d]  <= model_mask(expanded_key, cpc_of(d));
            acc_cnt[d] <= acc_cnt[d] + 1;
            acc_cyc[d] <= cyc + 1;
          end
        end else if (m_busy[d]) begin
          if (m_cnt[d] == 1) begin
            m_busy[d]  <= 1'b0;
            m_valid[d] <= 1'b1;
          end
          m_cnt[d] <= m_cnt[d] - 1;
        end else if (out_ready) begin
          m_valid[d] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare and result capture ----------------
  logic [31:0] res_key  [2];
  logic [31:0] res_stage[2];
  logic        res_match[2];
  logic [7:0]  res_mask [2];
  int          lat_meas [2];
  logic        prev_ov  [2];

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("in_ready[%0d]", d), {31'd0, in_ready_o[d]}, {31'd0, !m_busy[d] && !m_valid[d]});
        chk($sformatf("out_valid[%0d]", d), {31'd0, out_valid_o[d]}, {31'd0, m_valid[d]});
        if (m_valid[d]) begin
          chk($sformatf("key[%0d]", d), key_o[d], m_key[d]);
          chk($sformatf("stage[%0d]", d), stage_o[d], m_stage[d]);
          chk($sformatf("err_mask[%0d]", d), {24'd0, err_mask_o[d]}, {24'd0, m_mask[d]});
          chk($sformatf("match[%0d]", d), {31'd0, match_o[d]}, {31'd0, m_mask[d] == 8'h00});
        end
        if (out_valid_o[d]) begin
          res_key[d]   = key_o[d];
          res_stage[d] = stage_o[d];
          res_match[d] = match_o[d];
          res_mask[d]  = err_mask_o[d];
          if (!prev_ov[d]) lat_meas[d] = cyc - acc_cyc[d] + 1;
        end
      end
    end
    for (int d = 0; d < 2; d++) prev_ov[d] = out_valid_o[d];
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_res();
    for (int d = 0; d < 2; d++) begin
      res_key[d] = 32'hDEADBEEF; res_stage[d] = 32'hDEADBEEF;
      res_match[d] = 1'bx; res_mask[d] = 8'hxx; lat_meas[d] = -1;
    end
  endtask

  task automatic send(input logic [255:0] v);
    int a0;
    int a1;
    int n;
    clear_res();
    @(negedge clk);
    a0 = acc_cnt[0];
    a1 = acc_cnt[1];
    expanded_key = v;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((acc_cnt[0] == a0 || acc_cnt[1] == a1) && n < 60);
    if (n >= 60) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy[0] || m_valid[0] || m_busy[1] || m_valid[1]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_in_ready"}, {31'd0, in_ready_o[d]}, 32'd1);
      chk({tag, "_out_valid"}, {31'd0, out_valid_o[d]}, 32'd0);
      chk({tag, "_key"}, key_o[d], 32'd0);
      chk({tag, "_stage"}, stage_o[d], 32'd0);
      chk({tag, "_match"}, {31'd0, match_o[d]}, 32'd0);
      chk({tag, "_err_mask"}, {24'd0, err_mask_o[d]}, 32'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    expanded_key = 256'd0;
    for (int d = 0; d < 2; d++) begin acc_cnt[d] = 0; acc_cyc[d] = 0; prev_ov[d] = 1'b0; end
    clear_res();
    #12;
    check_zero("reset");

    // Pin the model with hand-computed values.
    chk("model_e3_edge", exp_chunk(3, 32'h0, 32'hFFFFFFFF), 32'h00000000);
    chk("model_e5_edge", exp_chunk(5, 32'h0, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("model_e6_edge", exp_chunk(6, 32'h0, 32'hFFFFFFFF), 32'h1FFFFFFF);
    chk("model_e7_gold", exp_chunk(7, 32'h12345678, 32'h1), 32'hB791F3DC);
    @(negedge clk);
    rst_n = 1'b1;

    // Golden vector.
    send(GOLD);
    wait_idle();
    chk("gold_key", res_key[0], 32'h12345678);
    chk("gold_stage", res_stage[0], 32'h00000001);
    chk("gold_match", {31'd0, res_match[0]}, 32'd1);
    chk("gold_mask", {24'd0, res_mask[0]}, 32'h00);
    chk("gold_lat_cpc1", lat_meas[0], 32'd7);
    chk("gold_lat_cpc3", lat_meas[1], 32'd3);

    // Single corruption in chunk 5.
    send(CORR5);
    wait_idle();
    chk("corr5_mask", {24'd0, res_mask[0]}, 32'h20);
    chk("corr5_match", {31'd0, res_match[0]}, 32'd0);
    chk("corr5_key", res_key[0], 32'h12345678);
    chk("corr5_stage", res_stage[0], 32'h00000001);
`ifdef KEY_RECOVER_EARLY_ABORT_EN
    chk("corr5_lat", lat_meas[0], 32'd5);
`else
    chk("corr5_lat", lat_meas[0], 32'd7);
`endif

    // Chunks 2 and 7 corrupted, three chunks per cycle.
    send(MULTI);
    wait_idle();
`ifdef KEY_RECOVER_EARLY_ABORT_EN
    chk("multi_mask_cpc3", {24'd0, res_mask[1]}, 32'h04);
    chk("multi_lat_cpc3", lat_meas[1], 32'd2);
`else
    chk("multi_mask_cpc3", {24'd0, res_mask[1]}, 32'h84);
    chk("multi_lat_cpc3", lat_meas[1], 32'd3);
`endif
    chk("multi_match_cpc3", {31'd0, res_match[1]}, 32'd0);

    // All-ones stage, zero key.
    send(EDGEV);
    wait_idle();
    chk("edge_match_cpc1", {31'd0, res_match[0]}, 32'd1);
    chk("edge_match_cpc3", {31'd0, res_match[1]}, 32'd1);
    chk("edge_stage", res_stage[1], 32'hFFFFFFFF);

    // Backpressure in DONE with a second vector waiting.
    out_ready = 1'b0;
    send(GOLD);
    n = 0;
    while (!(m_valid[0] && m_valid[1]) && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("bp_done_timeout", 32'd0, 32'd1);
    expanded_key = MULTI;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("bp_in_ready", {31'd0, in_ready_o[d]}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid_o[d]}, 32'd1);
        chk("bp_key", key_o[d], 32'h12345678);
        chk("bp_mask", {24'd0, err_mask_o[d]}, 32'h00);
      end
    end
    clear_res();
    out_ready = 1'b1;
    n = acc_cnt[1];
    begin
      int t;
      t = 0;
      while (acc_cnt[1] == n && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) chk("bp_second_accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
    wait_idle();
`ifdef KEY_RECOVER_EARLY_ABORT_EN
    chk("bp_second_mask", {24'd0, res_mask[1]}, 32'h04);
`else
    chk("bp_second_mask", {24'd0, res_mask[1]}, 32'h84);
`endif

    // Asynchronous reset in the middle of CHECK.
    send(GOLD);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    send(GOLD);
    wait_idle();
    chk("post_reset_key", res_key[0], 32'h12345678);
    chk("post_reset_match", {31'd0, res_match[0]}, 32'd1);
    chk("post_reset_lat", lat_meas[0], 32'd7);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_recover_256to32.md
Name: key_recover_256to32

Overview:
- Inverse/checker for the 32-to-256 key expander.
- Accepts a 256-bit expanded key and recovers the 32-bit key and 32-bit stage from chunks 0 and 1.
- Regenerates chunks 2..7 and compares them serially against the input, reporting a per-chunk mismatch mask.
- Sits on the key-load path ahead of the round engine and rejects corrupted or forged key material.

Parameters:
- CHUNKS_PER_CYCLE, 1, number of chunks (2..7) compared per CHECK cycle. Legal values are 1, 2, 3, 6. Any other value is a fatal elaboration error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  expanded_key is valid.
- in_ready  output  1  block can accept a new expanded key.
- expanded_key  input  256  chunk i occupies bits [255-32i : 224-32i]; chunk 0 is the MSBs.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- key  output  32  recovered key.
- stage  output  32  recovered stage.
- match  output  1  1 when all chunks are consistent.
- err_mask  output  8  bit i set when chunk i mismatched.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; in_ready=1, out_valid=0, key=0, stage=0, match=0, err_mask=0; internal chunk register, group index and mask cleared.
- Recovery: K = chunk0; S = chunk0 ^ chunk1.
- Expected chunks:
  - E2 = K ^ {S[15:0],S[31:16]}
  - E3 = K ^ ~S
  - E4 = K ^ {S[23:0],S[31:24]}
  - E5 = K ^ (S<<1), logical shift, 32-bit truncated
  - E6 = K ^ (S>>3), logical shift
  - E7 = K ^ S ^ 32'hA5A5A5A5
- Mask rule: err_mask[0] and err_mask[1] are always 0, because chunks 0 and 1 define K and S.
- FSM states: IDLE, CHECK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: register the 256-bit input, K and S; clear the mask; group index g=0; go to CHECK.
- CHECK:
  - in_ready=0.
  - Each cycle compares chunks 2+g*CHUNKS_PER_CYCLE through 2+(g+1)*CHUNKS_PER_CYCLE-1 and ORs mismatches into the mask.
  - g increments each cycle.
  - After group G-1 (G = 6/CHUNKS_PER_CYCLE), go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - key, stage, err_mask and match (= err_mask==0) are stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE; out_valid deasserts next cycle.
- Latency: out_valid rises G+1 cycles after the accept cycle (7 cycles for CHUNKS_PER_CYCLE=1, 2 cycles for CHUNKS_PER_CYCLE=6).
- Throughput: one key per G+2 cycles maximum. No overlap: in_valid asserted in DONE is not accepted until IDLE.
- Input stability: expanded_key is sampled only at the accept edge; changes during CHECK are ignored.
- in_valid while busy: held off by in_ready=0. The source must hold in_valid and data until accepted.
- Reset mid-CHECK or mid-DONE: returns to IDLE immediately; the pending result is discarded and no out_valid is produced.
- Outputs are registered; no combinational path from in_* to out_*.

Optional Feature:
- Macro: KEY_RECOVER_EARLY_ABORT_EN.
- Defined:
  - If any mismatch is found in the current CHECK group, go directly to DONE after that group.
  - err_mask holds only the groups checked so far; unchecked chunks read 0. match=0.
- Undefined: all G groups are always checked and the latency is fixed at G+1.

Test Plan:
- Golden vector: K=0x12345678, S=0x00000001, consistent vector (chunk1=0x12345679, chunk7=0xB791F3DC, etc.), CHUNKS_PER_CYCLE=1.
  - Required: key=0x12345678, stage=0x00000001, match=1, err_mask=0x00, out_valid 7 cycles after accept.
- Single corruption: golden vector with bit 0 of chunk 5 flipped.
  - Required: err_mask=0x20, match=0, key/stage unchanged.
  - With KEY_RECOVER_EARLY_ABORT_EN: out_valid 5 cycles after accept.
- Multiple corruption: chunk 2 and chunk 7 both corrupted, CHUNKS_PER_CYCLE=3, no abort.
  - Required: err_mask=0x84, out_valid 3 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with a new vector.
  - Required: outputs stable, in_ready=0 throughout.
  - After out_ready pulse: IDLE, then accept of the second vector.
- Async reset: assert rst_n=0 mid-CHECK (cycle 3).
  - Required: out_valid=0, in_ready=1, all outputs 0 immediately.
  - After release: the next golden vector completes normally.
- Edge stage: S=0xFFFFFFFF, K=0.
  - Required: E3=0x00000000, E5=0xFFFFFFFE, E6=0x1FFFFFFF; consistent vector gives match=1.
